// File: rtl/exmem_pkg.sv
// Shared types, constants and helpers for the prefetching BRAM front end.
package exmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_e;

  // Default decode value for wbs_adr_i[31:24].
  localparam logic [7:0] ADDR_BASE = 8'h38;

  // Width of the BRAM word address carried in wbs_adr_i[23:2].
  localparam int WORD_W = 22;

  // Ceiling log2, used for elaboration-time index widths.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((32'sd1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

  // First word address of the aligned line containing word.
  function automatic logic [WORD_W-1:0] line_base(input logic [WORD_W-1:0] word,
                                                  input int line_words);
    return word & ~(WORD_W'(line_words) - 22'd1);
  endfunction

endpackage

// File: rtl/exmem_prefetch_if.sv
// Wishbone slave-side signal bundle between the bus and the prefetcher.
interface exmem_wb_if #(
  parameter int BITS = 32
);
  logic            wbs_stb_i;
  logic            wbs_cyc_i;
  logic            wbs_we_i;
  logic [3:0]      wbs_sel_i;
  logic [BITS-1:0] wbs_dat_i;
  logic [31:0]     wbs_adr_i;
  logic            wbs_ack_o;
  logic [BITS-1:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/exmem_line_buf.sv
// One-line buffer: LINE_WORDS words with byte-masked write, tag and valid flag.
module exmem_line_buf
  import exmem_pkg::*;
#(
  parameter int BITS       = 32,
  parameter int LINE_WORDS = 4,
  parameter int OFF_W      = 2,
  parameter int TAG_W      = 20
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [OFF_W-1:0] wr_idx,
  input  logic [3:0]       wr_sel,
  input  logic [BITS-1:0]  wr_data,
  input  logic [OFF_W-1:0] rd_idx,
  output logic [BITS-1:0]  rd_data,
  input  logic             tag_we,
  input  logic [TAG_W-1:0] tag_in,
  output logic [TAG_W-1:0] tag_out,
  input  logic             valid_set,
  input  logic             valid_clr,
  output logic             line_valid
);

  logic [BITS-1:0]  mem_r [LINE_WORDS];
  logic [TAG_W-1:0] tag_r;
  logic             valid_r;

  // Word storage with per-byte write enables.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_sel[i]) begin
          mem_r[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Tag and valid flag; a clear (new miss) beats a set.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tag_r   <= '0;
      valid_r <= 1'b0;
    end else begin
      if (tag_we) begin
        tag_r <= tag_in;
      end
      if (valid_clr) begin
        valid_r <= 1'b0;
      end else if (valid_set) begin
        valid_r <= 1'b1;
      end
    end
  end

  assign rd_data    = mem_r[rd_idx];
  assign tag_out    = tag_r;
  assign line_valid = valid_r;

endmodule

// File: rtl/exmem_prefetch.sv
// Wishbone-to-BRAM front end with a single-line read prefetch buffer.
module exmem_prefetch #(
  parameter int         BITS       = 32,
  parameter int         LINE_WORDS = 4,
  parameter int         BRAM_LAT   = 1,
  parameter logic [7:0] ADDR_BASE  = exmem_pkg::ADDR_BASE
) (
  input  logic            wb_clk_i,
  input  logic            wb_rstn_i,
  exmem_wb_if.slave       wb,
  output logic            bram_en,
  output logic [3:0]      bram_we,
  output logic [BITS-1:0] bram_adr,
  output logic [BITS-1:0] bram_di,
  input  logic [BITS-1:0] bram_do
);
  import exmem_pkg::*;

  localparam int               OFF_W    = clog2(LINE_WORDS);
  localparam int               TAG_W    = WORD_W - OFF_W;
  localparam logic [OFF_W:0]   LW_C     = (OFF_W+1)'(LINE_WORDS);
  localparam logic [OFF_W-1:0] LAST_IDX = OFF_W'(LINE_WORDS - 1);

  state_e state_r, state_s;

  logic [WORD_W-1:0] word_s;
  logic [OFF_W-1:0]  off_s;
  logic [TAG_W-1:0]  tag_s;
  logic              req_s, hit_s;

  logic [OFF_W:0]    iss_cnt_r, iss_cnt_s;
  logic [OFF_W-1:0]  req_off_r, req_off_s;
  logic [TAG_W-1:0]  req_tag_r, req_tag_s;

  logic              ack_r, ack_s;
  logic [BITS-1:0]   dat_r, dat_s;
  logic              en_r, en_s;
  logic [3:0]        we_r, we_s;
  logic [BITS-1:0]   adr_r, adr_s;
  logic [BITS-1:0]   di_r, di_s;
  logic              fiss_r, fiss_s;
  logic [OFF_W-1:0]  fidx_r, fidx_s;

  logic              rv_vld_r [BRAM_LAT];
  logic [OFF_W-1:0]  rv_idx_r [BRAM_LAT];
  logic              ret_vld_s;
  logic [OFF_W-1:0]  ret_idx_s;

  logic              bw_en_s, tag_we_s, vset_s, vclr_s, line_valid_s;
  logic [OFF_W-1:0]  bw_idx_s;
  logic [3:0]        bw_sel_s;
  logic [BITS-1:0]   bw_data_s, rd_data_s;
  logic [TAG_W-1:0]  tag_q_s;
  logic              unused_s;

  assign word_s    = wb.wbs_adr_i[23:2];
  assign off_s     = word_s[OFF_W-1:0];
  assign tag_s     = word_s[WORD_W-1:OFF_W];
  assign req_s     = wb.wbs_stb_i & wb.wbs_cyc_i &
                     (wb.wbs_adr_i[31:24] == ADDR_BASE) & ~ack_r;
  assign hit_s     = line_valid_s & (tag_s == tag_q_s);
  assign ret_vld_s = rv_vld_r[BRAM_LAT-1];
  assign ret_idx_s = rv_idx_r[BRAM_LAT-1];
  assign unused_s  = ^wb.wbs_adr_i[1:0];

  exmem_line_buf #(
    .BITS(BITS), .LINE_WORDS(LINE_WORDS), .OFF_W(OFF_W), .TAG_W(TAG_W)
  ) u_buf (
    .clk(wb_clk_i), .rstn(wb_rstn_i),
    .wr_en(bw_en_s), .wr_idx(bw_idx_s), .wr_sel(bw_sel_s), .wr_data(bw_data_s),
    .rd_idx(off_s), .rd_data(rd_data_s),
    .tag_we(tag_we_s), .tag_in(req_tag_r), .tag_out(tag_q_s),
    .valid_set(vset_s), .valid_clr(vclr_s), .line_valid(line_valid_s)
  );

  // FSM state register.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state, next registered outputs and line-buffer write controls.
  always_comb begin
    state_s   = state_r;
    iss_cnt_s = iss_cnt_r;
    req_off_s = req_off_r;
    req_tag_s = req_tag_r;
    ack_s     = 1'b0;
    dat_s     = '0;
    en_s      = 1'b0;
    we_s      = 4'b0000;
    adr_s     = '0;
    di_s      = '0;
    fiss_s    = 1'b0;
    fidx_s    = '0;
    bw_en_s   = 1'b0;
    bw_idx_s  = off_s;
    bw_sel_s  = 4'b0000;
    bw_data_s = wb.wbs_dat_i;
    tag_we_s  = 1'b0;
    vset_s    = 1'b0;
    vclr_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          if (wb.wbs_we_i) begin
            state_s = WRITE;
            en_s    = 1'b1;
            we_s    = wb.wbs_sel_i;
            di_s    = wb.wbs_dat_i;
            adr_s   = BITS'(word_s);
            if (hit_s) begin
              bw_en_s  = 1'b1;
              bw_sel_s = wb.wbs_sel_i;
            end else begin
              bw_en_s  = 1'b0;
            end
          end else if (hit_s) begin
            ack_s = 1'b1;
            dat_s = rd_data_s;
          end else begin
            vclr_s    = 1'b1;
            req_tag_s = tag_s;
            req_off_s = off_s;
            state_s   = FILL;
            en_s      = 1'b1;
            fiss_s    = 1'b1;
            fidx_s    = '0;
            adr_s     = BITS'(line_base(word_s, LINE_WORDS));
            iss_cnt_s = (OFF_W+1)'(1);
          end
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        if (iss_cnt_r < LW_C) begin
          en_s      = 1'b1;
          fiss_s    = 1'b1;
          fidx_s    = iss_cnt_r[OFF_W-1:0];
          adr_s     = BITS'({req_tag_r, iss_cnt_r[OFF_W-1:0]});
          iss_cnt_s = iss_cnt_r + (OFF_W+1)'(1);
        end else begin
          en_s = 1'b0;
        end
        if (ret_vld_s) begin
          bw_en_s   = 1'b1;
          bw_idx_s  = ret_idx_s;
          bw_sel_s  = 4'b1111;
          bw_data_s = bram_do;
          if (ret_idx_s == req_off_r) begin
            // Critical word: ack unless the master has abandoned the cycle.
            ack_s = wb.wbs_cyc_i;
            dat_s = {BITS{wb.wbs_cyc_i}} & bram_do;
          end else begin
            ack_s = 1'b0;
          end
          if (ret_idx_s == LAST_IDX) begin
            vset_s    = 1'b1;
            tag_we_s  = 1'b1;
            state_s   = IDLE;
            iss_cnt_s = '0;
          end else begin
            state_s = FILL;
          end
        end else begin
          bw_en_s = 1'b0;
        end
      end
      WRITE: begin
        ack_s   = wb.wbs_cyc_i;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Registered bus/BRAM outputs and fill bookkeeping.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      iss_cnt_r <= '0;
      req_off_r <= '0;
      req_tag_r <= '0;
      ack_r     <= 1'b0;
      dat_r     <= '0;
      en_r      <= 1'b0;
      we_r      <= 4'b0000;
      adr_r     <= '0;
      di_r      <= '0;
      fiss_r    <= 1'b0;
      fidx_r    <= '0;
    end else begin
      iss_cnt_r <= iss_cnt_s;
      req_off_r <= req_off_s;
      req_tag_r <= req_tag_s;
      ack_r     <= ack_s;
      dat_r     <= dat_s;
      en_r      <= en_s;
      we_r      <= we_s;
      adr_r     <= adr_s;
      di_r      <= di_s;
      fiss_r    <= fiss_s;
      fidx_r    <= fidx_s;
    end
  end

  // Return pipeline: tracks which line index bram_do carries BRAM_LAT cycles later.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      for (int i = 0; i < BRAM_LAT; i++) begin
        rv_vld_r[i] <= 1'b0;
        rv_idx_r[i] <= '0;
      end
    end else begin
      rv_vld_r[0] <= fiss_r;
      rv_idx_r[0] <= fidx_r;
      for (int i = 1; i < BRAM_LAT; i++) begin
        rv_vld_r[i] <= rv_vld_r[i-1];
        rv_idx_r[i] <= rv_idx_r[i-1];
      end
    end
  end

  assign wb.wbs_ack_o = ack_r;
  assign wb.wbs_dat_o = dat_r;
  assign bram_en      = en_r;
  assign bram_we      = we_r;
  assign bram_adr     = adr_r;
  assign bram_di      = di_r;

endmodule

// File: doc/exmem_prefetch.md
Name: exmem_prefetch

Overview:
- Sits between the Wishbone slave bus and the user BRAM, upstream of the BRAM wrapper. It replaces the fixed-delay ack path.
- Holds one line buffer of LINE_WORDS words. A read miss fetches the whole aligned line from BRAM with pipelined single-word reads; a read hit acks in one cycle.
- Writes go straight through to BRAM with byte enables. If the written address is in the buffered line, the buffer is updated too.

Parameters:
- BITS, 32, data width; also the width of the BRAM address port.
- LINE_WORDS, 4, words per line; power of 2, range 2..16.
- BRAM_LAT, 1, cycles from bram_en high to bram_do valid; range 1..15.
- ADDR_BASE, 8'h38, decode value for wbs_adr_i[31:24].

Ports:
- wb_clk_i  in  1  the only clock.
- wb_rstn_i  in  1  reset, synchronous, active-low.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  1 = write.
- wbs_sel_i  in  4  byte enables.
- wbs_dat_i  in  BITS  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  registered, single-cycle ack.
- wbs_dat_o  out  BITS  read data; 0 when ack is low.
- bram_en  out  1  BRAM access enable.
- bram_we  out  4  BRAM byte write enables.
- bram_adr  out  BITS  BRAM word address = wbs_adr_i[23:2], zero-extended.
- bram_di  out  BITS  BRAM write data.
- bram_do  in  BITS  BRAM read data, valid BRAM_LAT cycles after bram_en.

Behaviour:
- Reset (wb_rstn_i=0 at a clock edge): every output is 0, state=IDLE, line_valid=0, all counters 0. Reset mid-fill or mid-write aborts the operation and issues no ack.
- Request condition: stb & cyc & (adr[31:24]==ADDR_BASE) & !wbs_ack_o, sampled only in IDLE. Addresses that fail the decode are never acked.
- Address split: word = adr[23:2]; offset = low log2(LINE_WORDS) bits of word; tag = the remaining upper bits.
- A hit requires line_valid=1 and a tag match.
- All timings below take the request as sampled in cycle T.
- State IDLE:
  - Read hit: ack=1 and dat_o=buffer[offset] at T+1; stay in IDLE.
  - Read miss: line_valid<=0, latch tag and offset, go to FILL.
  - Write: go to WRITE.
- State FILL:
  - Issue bram_en=1, we=0 for word addresses line_base+0 .. line_base+LINE_WORDS-1, one per cycle from T+1 to T+LINE_WORDS. Fill order is always ascending from the line base.
  - A return-pipeline shift register of depth BRAM_LAT tracks the index of each issued word.
  - The word issued at T+1+k is captured into buffer[k] at T+1+k+BRAM_LAT.
  - When the requested offset o is captured, ack=1 and dat_o=that word at T+2+o+BRAM_LAT (critical-word ack before the fill completes).
  - After the last capture: line_valid<=1, tag committed, go to IDLE.
  - New requests are not sampled during FILL.
- State WRITE:
  - At T+1: bram_en=1, bram_we=wbs_sel_i, bram_di=wbs_dat_i, bram_adr=word.
  - On a hit, the selected bytes are merged into buffer[offset] at the same edge.
  - At T+2: ack=1, dat_o=0. Return to IDLE.
- Ack cancel: if wbs_cyc_i=0 in the cycle an ack would be registered, the ack is suppressed.
  - During FILL the fill still completes and the line becomes valid.
  - During WRITE the BRAM write still happens.
- bram_en and bram_we are 0 in every cycle not listed above.
- wbs_ack_o is never high for two consecutive cycles.

Decomposition:
- Shared package exmem_pkg holds:
  - the state enum {IDLE, FILL, WRITE};
  - ADDR_BASE;
  - the functions clog2 and line_base(word).
- One sub-module, exmem_line_buf, holds:
  - LINE_WORDS x BITS storage with a byte-masked write port, one read port and a tag register;
  - line_valid with its clear and set controls.

Test Plan (defaults: LINE_WORDS=4, BRAM_LAT=1; BRAM model preloaded with mem[i]=0xA000_0000+i):
1. Cold read of 0x3800_0000 sampled at T -> bram_en high T+1..T+4 with adr 0,1,2,3; ack at T+3 with 0xA000_0000; line valid at T+6; then read 0x3800_000C -> ack on the next cycle with 0xA000_0003 and no bram_en.
2. Cold read of 0x3800_001C (offset 3, line 1) -> fill adr 4..7; ack at T+6 with 0xA000_0007.
3. With line 0 valid, write 0x3800_0004 with sel=4'b0011 and data 0x1234_5678 -> bram_we=0011 at T+1, ack at T+2; reread -> 0xA000_5678 on a hit, no bram_en.
4. Write to 0x3800_0040 (miss) -> BRAM written, line 0 stays valid and unchanged; a following read of 0x3800_0040 -> fill of adr 16..19, data 0x1234_5678 if sel=4'hF.
5. Read of 0x3000_0000 -> no ack and no bram_en for 20 cycles.
6. Two cases:
   - wb_rstn_i=0 for one cycle at T+2 of a miss -> all outputs 0 next cycle, no ack, next read of the same address refills.
   - cyc dropped at T+2 of a miss -> no ack, but the following read hits.
